// File: rtl/game_pkg.sv
// Shared types and defaults for the game-mode controller.
package game_pkg;

  typedef enum logic [1:0] {
    START       = 2'd0,
    GAME        = 2'd1,
    PLAYER1_WIN = 2'd2,
    PLAYER2_WIN = 2'd3
  } game_mode;

  localparam int WIN_HOLD_FRAMES_DEF       = 300;
  localparam int START_DEBOUNCE_FRAMES_DEF = 3;

endpackage

// File: rtl/frame_debounce.sv
// Frame-tick debounce: one press pulse per held level, saturating count.
module frame_debounce #(
  parameter int FRAMES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic level,
  output logic press
);

  localparam int CW = $clog2(FRAMES + 1);

  logic [CW-1:0] cnt;

  assign press = tick & level & (cnt == CW'(FRAMES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      if (!level)
        cnt <= '0;
      else if (cnt != CW'(FRAMES))
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_mode_ctrl.sv
// Frame-synchronous screen sequencer: START -> GAME -> win -> START.
// Optional WIN_SKIP_EN: a press on a win screen returns to START.
module game_mode_ctrl
  import game_pkg::*;
#(
  parameter int WIN_HOLD_FRAMES       = WIN_HOLD_FRAMES_DEF,
  parameter int START_DEBOUNCE_FRAMES = START_DEBOUNCE_FRAMES_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     vblnk,
  input  logic     btn_start,
  input  logic     p1_dead,
  input  logic     p2_dead,
  output game_mode mode,
  output logic     map_init,
  output logic [$clog2(WIN_HOLD_FRAMES+1)-1:0] hold_left
);

  localparam int HW = $clog2(WIN_HOLD_FRAMES + 1);

  logic          vblnk_q;
  logic          armed;
  logic          tick;
  logic          press;
  game_mode      state, state_n;
  logic [HW-1:0] hold_q, hold_n;
  logic          p1_lat, p1_n;
  logic          p2_lat, p2_n;
  logic          map_q, map_n;

  // armed blocks a tick from a vblnk already high at reset release
  assign tick = vblnk & ~vblnk_q & armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
      if (!vblnk)
        armed <= 1'b1;
    end
  end

  frame_debounce #(
    .FRAMES(START_DEBOUNCE_FRAMES)
  ) u_deb (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .level(btn_start),
    .press(press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= START;
      hold_q <= '0;
      p1_lat <= 1'b0;
      p2_lat <= 1'b0;
      map_q  <= 1'b0;
    end else begin
      state  <= state_n;
      hold_q <= hold_n;
      p1_lat <= p1_n;
      p2_lat <= p2_n;
      map_q  <= map_n;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_q;
    map_n   = 1'b0;
    p1_n    = p1_lat;
    p2_n    = p2_lat;
    if (state == GAME) begin
      p1_n = p1_lat | p1_dead;
      p2_n = p2_lat | p2_dead;
    end
    if (tick) begin
      unique case (state)
        START: begin
          if (press) begin
            state_n = GAME;
            map_n   = 1'b1;
            p1_n    = 1'b0;
            p2_n    = 1'b0;
          end
        end
        GAME: begin
          if (p1_n && p2_n) begin
            state_n = START;
          end else if (p2_n) begin
            state_n = PLAYER1_WIN;
            hold_n  = HW'(WIN_HOLD_FRAMES);
          end else if (p1_n) begin
            state_n = PLAYER2_WIN;
            hold_n  = HW'(WIN_HOLD_FRAMES);
          end
        end
        PLAYER1_WIN, PLAYER2_WIN: begin
`ifdef WIN_SKIP_EN
          if (press) begin
            state_n = START;
            hold_n  = '0;
          end else
`endif
          if (hold_q <= HW'(1)) begin
            state_n = START;
            hold_n  = '0;
          end else begin
            hold_n = hold_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign mode      = state;
  assign hold_left = hold_q;
  assign map_init  = map_q;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Frame-level bench for game_mode_ctrl with short synthetic frames.
module tb_game_mode_ctrl;
  import game_pkg::*;

  typedef struct {
    logic     btn;
    logic     p1;
    logic     p2;
    game_mode m;
    int       h;
    int       mi;
  } vec_t;

  typedef struct {
    game_mode m;
    int       h;
    int       mi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vblnk = 1'b0;
  logic       btn_start = 1'b0;
  logic       p1_dead = 1'b0;
  logic       p2_dead = 1'b0;
  game_mode   mode;
  logic       map_init;
  logic [2:0] hold_left;

  int checks = 0;
  int failures = 0;
  int map_seen = 0;

  vec_t vecs[$];
  exp_t sb[$];

  game_mode_ctrl #(
    .WIN_HOLD_FRAMES(4),
    .START_DEBOUNCE_FRAMES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vblnk    (vblnk),
    .btn_start(btn_start),
    .p1_dead  (p1_dead),
    .p2_dead  (p2_dead),
    .mode     (mode),
    .map_init (map_init),
    .hold_left(hold_left)
  );

  always #5 clk = ~clk;

  always @(posedge clk) map_seen <= map_seen + int'(map_init);

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic add(input logic b, input logic a1, input logic a2,
                     input game_mode m, input int h, input int mi);
    vec_t v;
    v.btn = b; v.p1 = a1; v.p2 = a2;
    v.m = m; v.h = h; v.mi = mi;
    vecs.push_back(v);
  endtask

  task automatic do_frame(input vec_t v, input int idx);
    exp_t e;
    e.m = v.m; e.h = v.h; e.mi = v.mi;
    sb.push_back(e);
    @(negedge clk);
    map_seen = 0;
    btn_start = v.btn;
    for (int i = 0; i < 6; i++) begin
      vblnk = 1'b0;
      p1_dead = (i == 2) && v.p1;
      p2_dead = (i == 2) && v.p2;
      @(negedge clk);
    end
    p1_dead = 1'b0;
    p2_dead = 1'b0;
    vblnk = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("mode[%0d]", idx), int'(mode), int'(e.m));
    chk($sformatf("hold[%0d]", idx), int'(hold_left), e.h);
    repeat (2) @(negedge clk);
    chk($sformatf("map_pulses[%0d]", idx), map_seen, e.mi);
  endtask

  task automatic run_table(input int base);
    for (int i = 0; i < vecs.size(); i++)
      do_frame(vecs[i], base + i);
    vecs.delete();
  endtask

  initial begin
    add(0, 0, 0, START, 0, 0);
    add(0, 0, 0, START, 0, 0);
    add(1, 0, 0, START, 0, 0);
    add(0, 0, 0, START, 0, 0);
    add(1, 0, 0, START, 0, 0);
    add(1, 0, 0, GAME, 0, 1);
    for (int i = 0; i < 10; i++)
      add(1, 0, 0, GAME, 0, 0);
    add(0, 0, 0, GAME, 0, 0);
    add(0, 0, 1, PLAYER1_WIN, 4, 0);
    add(0, 0, 0, PLAYER1_WIN, 3, 0);
    add(0, 0, 0, PLAYER1_WIN, 2, 0);
    add(0, 0, 0, PLAYER1_WIN, 1, 0);
    add(0, 0, 0, START, 0, 0);
    add(1, 0, 0, START, 0, 0);
    add(1, 0, 0, GAME, 0, 1);
    add(0, 0, 0, GAME, 0, 0);
    add(0, 1, 1, START, 0, 0);
    add(0, 1, 0, START, 0, 0);
    add(1, 0, 0, START, 0, 0);
    add(1, 0, 0, GAME, 0, 1);
    add(0, 0, 0, GAME, 0, 0);
    add(0, 1, 0, PLAYER2_WIN, 4, 0);
    add(0, 0, 0, PLAYER2_WIN, 3, 0);
    add(0, 0, 0, PLAYER2_WIN, 2, 0);

    repeat (3) @(negedge clk);
    chk("rst_mode", int'(mode), int'(START));
    chk("rst_hold", int'(hold_left), 0);
    chk("rst_map", int'(map_init), 0);
    rst = 1'b0;

    run_table(0);

    // reset mid-hold, with vblnk and button high across release
    @(negedge clk);
    map_seen = 0;
    rst = 1'b1;
    btn_start = 1'b1;
    vblnk = 1'b1;
    @(negedge clk);
    chk("midrst_mode", int'(mode), int'(START));
    chk("midrst_hold", int'(hold_left), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_map", map_seen, 0);
    chk("rel_mode", int'(mode), int'(START));

    add(1, 0, 0, START, 0, 0);
    add(1, 0, 0, GAME, 0, 1);
    add(0, 0, 0, GAME, 0, 0);
    add(0, 0, 1, PLAYER1_WIN, 4, 0);
    add(1, 0, 0, PLAYER1_WIN, 3, 0);
`ifdef WIN_SKIP_EN
    add(1, 0, 0, START, 0, 0);
    add(0, 0, 0, START, 0, 0);
    add(0, 0, 0, START, 0, 0);
`else
    add(1, 0, 0, PLAYER1_WIN, 2, 0);
    add(0, 0, 0, PLAYER1_WIN, 1, 0);
    add(0, 0, 0, START, 0, 0);
`endif
    run_table(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
